// File: rtl/click_sequence_checker.sv
// -----------------------------------------------------------------------------
// click_sequence_checker
//
// Checks a player's tile clicks against a stored sequence. A round starts on
// `start`. For each entry the block fetches the expected tile index from an
// external store, waits for a single rising edge on `button_pressed`, then
// compares the clicked tile against the expected one. A full match pulses
// `success`. A wrong tile, two or more simultaneous edges, or an optional
// timeout pulses `fail`.
//
// Optional feature: define CLICK_TIMEOUT_EN to add a per-click timeout of
// TIMEOUT_CYCLES clocks in WAIT_CLICK. Without it, WAIT_CLICK waits forever.
//
// Ports
//   clk            in   clock; all state updates on the rising edge
//   rst            in   asynchronous, active-low reset
//   start          in   one-cycle pulse that begins a round (IDLE only)
//   seq_len[5:0]   in   clicks expected; 0 -> 1, values > SEQ_MAX clamp to SEQ_MAX
//   button_pressed in   level per tile, NUM_BUTTONS bits
//   seq_addr[5:0]  out  index of the expected entry in the sequence store
//   seq_data       in   expected tile index read from the store (IDX_W bits)
//   busy           out  high in every state except IDLE
//   success        out  one-cycle pulse when the whole sequence matched
//   fail           out  one-cycle pulse on wrong click, multi-click or timeout
//   step[5:0]      out  number of correct clicks in the current round
//   last_idx       out  tile index of the most recent single click
// -----------------------------------------------------------------------------
module click_sequence_checker #(
    parameter int NUM_BUTTONS    = 16,
    parameter int IDX_W          = 4,
    parameter int SEQ_MAX        = 32,
    parameter int TIMEOUT_CYCLES = 65_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [5:0]             seq_len,
    input  logic [NUM_BUTTONS-1:0] button_pressed,
    output logic [5:0]             seq_addr,
    input  logic [IDX_W-1:0]       seq_data,
    output logic                   busy,
    output logic                   success,
    output logic                   fail,
    output logic [5:0]             step,
    output logic [IDX_W-1:0]       last_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_CLICK,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [5:0]             len_q, len_d;
    logic [5:0]             step_q, step_d;
    logic [5:0]             addr_q, addr_d;
    logic [IDX_W-1:0]       exp_q, exp_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_BUTTONS-1:0] prev_q;
    logic                   success_q, success_d;
    logic                   fail_q, fail_d;
    logic                   busy_q, busy_d;

    logic [NUM_BUTTONS-1:0] rise;
    logic                   single_click;
    logic                   multi_click;
    logic [IDX_W-1:0]       rise_idx;
    logic                   timed_out;

    // A length of 0 still means one click; anything too long uses the maximum.
    function automatic logic [5:0] clamp_len(input logic [5:0] l);
        logic [5:0] r;
        if (l == 6'd0)
            r = 6'd1;
        else if (l > 6'(SEQ_MAX))
            r = 6'(SEQ_MAX);
        else
            r = l;
        return r;
    endfunction

    // A click is a rising edge. The edge register follows the buttons every
    // cycle, so edges outside WAIT_CLICK are consumed and never queued.
    always_comb begin
        rise         = button_pressed & ~prev_q;
        single_click = (rise != '0) && ((rise & (rise - NUM_BUTTONS'(1))) == '0);
        multi_click  = (rise != '0) && !single_click;
        rise_idx     = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (rise[i])
                rise_idx = IDX_W'(i);
        end
    end

`ifdef CLICK_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] tcnt_q, tcnt_d;

    assign timed_out = (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // The counter is held at zero outside WAIT_CLICK. That makes it read 0 in
    // the first WAIT_CLICK cycle, with no separate entry detection.
    always_comb begin
        tcnt_d = '0;
        if (state_q == S_WAIT_CLICK && state_d == S_WAIT_CLICK)
            tcnt_d = tcnt_q + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tcnt_q <= '0;
        else
            tcnt_q <= tcnt_d;
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        step_d    = step_q;
        addr_d    = addr_q;
        exp_d     = exp_q;
        last_d    = last_q;
        success_d = 1'b0;
        fail_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    step_d  = 6'd0;
                    addr_d  = 6'd0;
                    len_d   = clamp_len(seq_len);
                end
            end
            S_FETCH: begin
                exp_d   = seq_data;
                state_d = S_WAIT_CLICK;
            end
            S_WAIT_CLICK: begin
                // A click always takes priority over a timeout in the same cycle.
                if (single_click) begin
                    last_d  = rise_idx;
                    state_d = S_CHECK;
                end else if (multi_click) begin
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end else if (timed_out) begin
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_CHECK: begin
                if (last_q == exp_q) begin
                    step_d = step_q + 6'd1;
                    if (step_q + 6'd1 == len_q) begin
                        success_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        addr_d  = addr_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            len_q     <= 6'd1;
            step_q    <= 6'd0;
            addr_q    <= 6'd0;
            exp_q     <= '0;
            last_q    <= '0;
            prev_q    <= '0;
            success_q <= 1'b0;
            fail_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            step_q    <= step_d;
            addr_q    <= addr_d;
            exp_q     <= exp_d;
            last_q    <= last_d;
            prev_q    <= button_pressed;
            success_q <= success_d;
            fail_q    <= fail_d;
            busy_q    <= busy_d;
        end
    end

    assign seq_addr = addr_q;
    assign busy     = busy_q;
    assign success  = success_q;
    assign fail     = fail_q;
    assign step     = step_q;
    assign last_idx = last_q;

endmodule
